trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
// - Sequences M-mode trap entry/return around csr_file: arbitrates sync exceptions, pending interrupts, MRET.
// - Drains pipeline, pulses csr_file trap/mret strobes, issues one PC redirect to fetch.
// - Sits between decode/execute trap sources, csr_file, fetch redirect. Only writer of csr_file trap inputs.
// PARAMETERS
// - XLEN        32  datapath width; equals MXLEN
// - DRAIN_MAX   15  max DRAIN cycles before forced commit; 1..255
// PORTS
// - i_clk            in   1     clock
// - i_rst_n          in   1     reset, asynchronous, active-low
// - i_exc_valid      in   1     sync exception reported by execute
// - i_exc_cause      in   XLEN  exception cause, trap_cause_t, MSB=0
// - i_exc_tval       in   XLEN  exception tval
// - i_exc_pc         in   XLEN  PC of faulting instruction
// - i_mret           in   1     MRET retiring
// - i_irq_pc         in   XLEN  PC of next unretired instruction; mepc for interrupts
// - i_priv_mode      in   2     current priv_mode_t
// - i_mstatus/i_mie/i_mip  in  XLEN  live csr_file outputs
// - i_mtvec, i_mepc  in   XLEN  live csr_file outputs
// - i_pipe_drained   in   1     no in-flight instruction older than trap point
// - i_redirect_ready in   1     fetch accepts redirect
// - o_flush          out  1     kill younger instructions; 1-cycle pulse
// - o_stall          out  1     hold front end; high in any non-IDLE state
// - o_trap_req, o_trap_mret  out 1  csr_file strobes; 1-cycle pulse, mutually exclusive
// - o_trap_cause, o_trap_tval, o_trap_pc  out XLEN  csr_file operands; valid with o_trap_req
// - o_redirect_valid out  1     redirect PC valid
// - o_redirect_pc    out  XLEN  new fetch PC
// - o_drain_timeout  out  1     sticky; set when DRAIN_MAX expired
// BEHAVIOUR
// - Reset (async, i_rst_n=0): state IDLE; all outputs 0; latched cause/tval/pc 0; drain counter 0.
// - irq_pend = |(i_mie & i_mip & {MEIE,MSIE,MTIE bits}) && (i_mstatus.mie || i_priv_mode<PRIV_M).
// - IRQ priority MEI(11) > MSI(3) > MTI(7). Cause = {1'b1, code}. tval = 0.
// - IDLE priority: i_exc_valid > i_mret > irq_pend. Winner latched (kind, cause, tval, pc). Next cycle: o_flush=1, enter DRAIN.
// - Exception: pc=i_exc_pc. Interrupt: pc=i_irq_pc. MRET: no operands.
// - DRAIN: o_stall=1, counter increments. Exit to COMMIT when i_pipe_drained or counter==DRAIN_MAX. Timeout exit also sets o_drain_timeout.
// - COMMIT (1 cycle): pulse o_trap_req (trap) or o_trap_mret (MRET). Sample target into redirect register:
//   - trap: {i_mtvec[XLEN-1:2],2'b00}
//   - MRET: i_mepc
//   Go REDIRECT.
// - REDIRECT: o_redirect_valid=1, o_redirect_pc stable until i_redirect_ready=1; that cycle is the handshake. Next cycle: IDLE.
// - Minimum latency event->redirect_valid: 3 cycles (IDLE latch, DRAIN 1 cycle, COMMIT).
// - Events arriving outside IDLE are ignored; o_stall guarantees none legally occur (bench asserts).
// - IRQ deasserts after IDLE latch: trap still taken with the latched cause.
// - Target PC uses mtvec at COMMIT, not at latch time.
// - Address arithmetic wraps mod 2^XLEN. i_mtvec[1:0]=2'b11 (reserved): treated as direct.
// - Async reset mid-sequence aborts with no strobe pulse. o_drain_timeout clears only on reset.
// CONFIGURATION
// - TRAP_CTRL_VECTORED_EN defined: if i_mtvec[1:0]==2'b01 and kind==interrupt, target = base + (code<<2).
//   Exceptions always go to base.
// - TRAP_CTRL_VECTORED_EN undefined: mode bits ignored; all traps go to base.
// STRUCTURE
// - cotm32_priv_pkg adds: trap_ctrl_state_t {IDLE,DRAIN,COMMIT,REDIRECT}; trap_kind_t {EXC,IRQ,MRET};
//   IRQ_CODE_MEI/MSI/MTI constants; mip/mie bit index constants. trap_cause_t stays in that package.
// - Sub-module trap_irq_prio: combinational, mie/mip/mstatus/priv -> irq_pend, irq_code.
// - FSM, drain counter and latch regs live in trap_ctrl.
// TESTING
// - i_exc_valid, cause=2, pc=0x100, mtvec=0x200, drained next cycle
//   -> o_flush@+1, o_trap_req@+2 (pc 0x100, cause 2), o_redirect_pc=0x200 until ready.
// - mstatus.mie=1, mie.MTIE=1, mip.MTIP=1, i_irq_pc=0x44
//   -> cause 0x80000007, o_trap_pc=0x44, tval 0.
// - MEIP+MTIP+MSIP all pending and enabled -> cause 0x8000000B.
//   Same cycle i_exc_valid -> exception wins.
// - i_mret, mepc=0x80 -> o_trap_mret pulse only (o_trap_req stays 0); redirect 0x80.
//   i_redirect_ready low 4 cycles -> pc held stable.
// - i_pipe_drained stuck 0, DRAIN_MAX=15 -> COMMIT after 15 DRAIN cycles; o_drain_timeout=1 until reset.
// - VECTORED_EN, mtvec=0x301, MSI -> redirect 0x30C; exception -> 0x300.
//   Async reset during REDIRECT -> all outputs 0 immediately.

Source files
------------

// File: rtl/cotm32_priv_pkg.sv
// cotm32_priv_pkg: machine-mode privilege types and constants shared by the
// trap sequencing logic.
// Contents:
//   priv_mode_t        current privilege level
//   trap_cause_t       mcause layout (interrupt flag + code)
//   trap_ctrl_state_t  trap_ctrl FSM states
//   trap_kind_t        kind of event latched by trap_ctrl
//   IRQ_CODE_*         machine interrupt cause codes
//   *_BIT              mstatus / mie / mip bit positions
package cotm32_priv_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_mode_t;

    typedef struct packed {
        logic        interrupt;
        logic [30:0] code;
    } trap_cause_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } trap_ctrl_state_t;

    typedef enum logic [1:0] {
        EXC  = 2'd0,
        IRQ  = 2'd1,
        MRET = 2'd2
    } trap_kind_t;

    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;

    // mie/mip enable and pending bits share positions
    localparam int MEI_BIT         = 11;
    localparam int MSI_BIT         = 3;
    localparam int MTI_BIT         = 7;
    localparam int MSTATUS_MIE_BIT = 3;

endpackage

// File: rtl/trap_irq_prio.sv
// trap_irq_prio: combinational machine-interrupt arbiter.
// Ports:
//   i_mstatus, i_mie, i_mip  live CSR values
//   i_priv_mode              current privilege level
//   o_irq_pend               an enabled interrupt is pending and globally allowed
//   o_irq_code               code of the highest-priority pending interrupt
// Priority: MEI > MSI > MTI.
module trap_irq_prio
    import cotm32_priv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mip,
    input  priv_mode_t      i_priv_mode,
    output logic            o_irq_pend,
    output logic [3:0]      o_irq_code
);

    logic [XLEN-1:0] pending;
    logic            global_en;
    logic            unused_bits;

    assign unused_bits = ^{i_mstatus, i_mie, i_mip};

    always_comb begin
        pending   = i_mie & i_mip;
        // Below M-mode, machine interrupts are taken regardless of mstatus.MIE
        global_en = i_mstatus[MSTATUS_MIE_BIT] || (2'(i_priv_mode) < 2'(PRIV_M));

        o_irq_code = 4'd0;
        if (pending[MEI_BIT])      o_irq_code = IRQ_CODE_MEI;
        else if (pending[MSI_BIT]) o_irq_code = IRQ_CODE_MSI;
        else if (pending[MTI_BIT]) o_irq_code = IRQ_CODE_MTI;

        o_irq_pend = global_en && (pending[MEI_BIT] || pending[MSI_BIT] || pending[MTI_BIT]);
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences M-mode trap entry and MRET around csr_file.
// Latches one event in IDLE (exception > MRET > interrupt), flushes, waits for
// the pipeline to drain (bounded by DRAIN_MAX), pulses the csr_file strobe,
// then presents a single fetch redirect until accepted.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_exc_valid/cause/tval/pc      synchronous exception from execute
//   i_mret                         MRET retiring
//   i_irq_pc                       mepc value for interrupts
//   i_priv_mode                    current privilege level
//   i_mstatus/mie/mip/mtvec/mepc   live csr_file values
//   i_pipe_drained                 no older instruction in flight
//   i_redirect_ready               fetch accepts redirect
//   o_flush                        1-cycle kill of younger instructions
//   o_stall                        front-end hold while sequencing
//   o_trap_req / o_trap_mret       csr_file strobes
//   o_trap_cause/tval/pc           csr_file operands for o_trap_req
//   o_redirect_valid/pc            fetch redirect
//   o_drain_timeout                sticky: drain bound expired
// Build option: define TRAP_CTRL_VECTORED_EN to honour mtvec vectored mode
// for interrupts; otherwise every trap targets the mtvec base.
module trap_ctrl
    import cotm32_priv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_exc_valid,
    input  logic [XLEN-1:0] i_exc_cause,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_irq_pc,
    input  priv_mode_t      i_priv_mode,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mip,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_pipe_drained,
    input  logic            i_redirect_ready,
    output logic            o_flush,
    output logic            o_stall,
    output logic            o_trap_req,
    output logic            o_trap_mret,
    output logic [XLEN-1:0] o_trap_cause,
    output logic [XLEN-1:0] o_trap_tval,
    output logic [XLEN-1:0] o_trap_pc,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_drain_timeout
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    trap_ctrl_state_t state, state_next;
    trap_kind_t       kind;
    logic [XLEN-1:0]  cause, tval, pc, redirect_pc, target, base;
    logic [7:0]       drain_cnt;
    logic             drain_last, flush, timeout, event_any;
    logic             irq_pend;
    logic [3:0]       irq_code;
    logic [XLEN-1:0]  irq_cause;

    trap_irq_prio #(.XLEN(XLEN)) u_prio (
        .i_mstatus   (i_mstatus),
        .i_mie       (i_mie),
        .i_mip       (i_mip),
        .i_priv_mode (i_priv_mode),
        .o_irq_pend  (irq_pend),
        .o_irq_code  (irq_code)
    );

    assign irq_cause  = {1'b1, {(XLEN-5){1'b0}}, irq_code};
    assign event_any  = i_exc_valid || i_mret || irq_pend;
    // Counter holds the number of DRAIN cycles already spent, so this is the
    // DRAIN_MAX-th cycle
    assign drain_last = (drain_cnt == DRAIN_LAST);

    // Redirect target, evaluated with mtvec/mepc as seen in COMMIT
    assign base = {i_mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
    always_comb begin
        if (kind == MRET)
            target = i_mepc;
        else if (kind == IRQ && i_mtvec[1:0] == 2'b01)
            target = base + {cause[XLEN-3:0], 2'b00};
        else
            target = base;
    end
`else
    logic unused_bits;
    assign unused_bits = ^i_mtvec[1:0];
    assign target = (kind == MRET) ? i_mepc : base;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (event_any) state_next = DRAIN;
            DRAIN:    if (i_pipe_drained || drain_last) state_next = COMMIT;
            COMMIT:   state_next = REDIRECT;
            REDIRECT: if (i_redirect_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        o_stall          = (state != IDLE);
        o_trap_req       = (state == COMMIT) && (kind != MRET);
        o_trap_mret      = (state == COMMIT) && (kind == MRET);
        o_redirect_valid = (state == REDIRECT);
        o_flush          = flush;
        o_trap_cause     = cause;
        o_trap_tval      = tval;
        o_trap_pc        = pc;
        o_redirect_pc    = redirect_pc;
        o_drain_timeout  = timeout;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kind        <= EXC;
            cause       <= '0;
            tval        <= '0;
            pc          <= '0;
            redirect_pc <= '0;
            drain_cnt   <= '0;
            flush       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                IDLE: begin
                    drain_cnt <= '0;
                    flush     <= event_any;
                    if (i_exc_valid) begin
                        kind  <= EXC;
                        cause <= i_exc_cause;
                        tval  <= i_exc_tval;
                        pc    <= i_exc_pc;
                    end else if (i_mret) begin
                        kind  <= MRET;
                        cause <= '0;
                        tval  <= '0;
                        pc    <= '0;
                    end else if (irq_pend) begin
                        kind  <= IRQ;
                        cause <= irq_cause;
                        tval  <= '0;
                        pc    <= i_irq_pc;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 8'd1;
                    if (!i_pipe_drained && drain_last) timeout <= 1'b1;
                end
                COMMIT:   redirect_pc <= target;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
    import cotm32_priv_pkg::*;

    localparam int XLEN      = 32;
    localparam int DRAIN_MAX = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            exc_valid, mret, pipe_drained, redirect_ready;
    logic [XLEN-1:0] exc_cause, exc_tval, exc_pc, irq_pc;
    logic [XLEN-1:0] mstatus, mie, mip, mtvec, mepc;
    priv_mode_t      priv;
    logic            flush, stall, trap_req, trap_mret, redirect_valid, drain_timeout;
    logic [XLEN-1:0] trap_cause, trap_tval, trap_pc, redirect_pc;

    typedef struct {
        logic        is_mret;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] pc;
    } commit_t;

    commit_t     cq[$];
    logic [31:0] rq[$];
    commit_t     mon_e;
    logic [31:0] mon_r;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_exc_valid      (exc_valid),
        .i_exc_cause      (exc_cause),
        .i_exc_tval       (exc_tval),
        .i_exc_pc         (exc_pc),
        .i_mret           (mret),
        .i_irq_pc         (irq_pc),
        .i_priv_mode      (priv),
        .i_mstatus        (mstatus),
        .i_mie            (mie),
        .i_mip            (mip),
        .i_mtvec          (mtvec),
        .i_mepc           (mepc),
        .i_pipe_drained   (pipe_drained),
        .i_redirect_ready (redirect_ready),
        .o_flush          (flush),
        .o_stall          (stall),
        .o_trap_req       (trap_req),
        .o_trap_mret      (trap_mret),
        .o_trap_cause     (trap_cause),
        .o_trap_tval      (trap_tval),
        .o_trap_pc        (trap_pc),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_drain_timeout  (drain_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: strobes and redirect handshakes pop expectations
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (trap_req || trap_mret) begin
                if (cq.size() == 0) begin
                    chk("unexpected_strobe", 32'(trap_req | trap_mret), 32'd0);
                end else begin
                    mon_e = cq.pop_front();
                    chk("sb_mret_strobe", 32'(trap_mret), 32'(mon_e.is_mret));
                    chk("sb_req_strobe", 32'(trap_req), 32'(!mon_e.is_mret));
                    if (!mon_e.is_mret) begin
                        chk("sb_cause", trap_cause, mon_e.cause);
                        chk("sb_tval", trap_tval, mon_e.tval);
                        chk("sb_pc", trap_pc, mon_e.pc);
                    end
                end
            end
            if (redirect_valid && redirect_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
                end else begin
                    mon_r = rq.pop_front();
                    chk("sb_redirect_pc", redirect_pc, mon_r);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_commit(input string tag);
        int n = 0;
        while (!(trap_req || trap_mret) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk(tag, 32'(trap_req | trap_mret), 32'd1);
    endtask

    task automatic finish_redirect(input int hold, input logic [31:0] exp_pc);
        int n = 0;
        while (!redirect_valid && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("redirect_timeout", 32'(redirect_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("redirect_hold_valid", 32'(redirect_valid), 32'd1);
            chk("redirect_hold_pc", redirect_pc, exp_pc);
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("idle_after_redirect", 32'(stall | redirect_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        exc_valid = 0; mret = 0; pipe_drained = 1; redirect_ready = 0;
        exc_cause = 0; exc_tval = 0; exc_pc = 0; irq_pc = 0;
        mstatus = 0; mie = 0; mip = 0; mtvec = 32'h200; mepc = 0;
        priv = PRIV_M;
        #3;
        chk("rst_outputs", {flush, stall, trap_req, trap_mret, redirect_valid, drain_timeout}, 32'd0);
        chk("rst_operands", trap_cause | trap_tval | trap_pc | redirect_pc, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Exception, drained on the first DRAIN cycle
        cq.push_back('{is_mret: 1'b0, cause: 32'h2, tval: 32'h55, pc: 32'h100});
        rq.push_back(32'h200);
        exc_valid = 1; exc_cause = 32'h2; exc_tval = 32'h55; exc_pc = 32'h100;
        pipe_drained = 0;
        step();
        exc_valid = 0;
        chk("exc_flush_p1", 32'(flush), 32'd1);
        chk("exc_stall_p1", 32'(stall), 32'd1);
        chk("exc_req_p1", 32'(trap_req), 32'd0);
        pipe_drained = 1;
        step();
        chk("exc_req_p2", 32'(trap_req), 32'd1);
        chk("exc_flush_p2", 32'(flush), 32'd0);
        chk("exc_pc_p2", trap_pc, 32'h100);
        step();
        chk("exc_rv_p3", 32'(redirect_valid), 32'd1);
        chk("exc_rpc_p3", redirect_pc, 32'h200);
        finish_redirect(2, 32'h200);

        // Machine timer interrupt; request drops after latch
        mstatus = 32'h8; mie = 32'h80; mip = 32'h80; irq_pc = 32'h44;
        cq.push_back('{is_mret: 1'b0, cause: 32'h8000_0007, tval: 32'h0, pc: 32'h44});
        rq.push_back(32'h200);
        step();
        mip = 0;
        wait_commit("mti_commit_timeout");
        chk("mti_cause", trap_cause, 32'h8000_0007);
        finish_redirect(0, 32'h200);

        // All three pending: external wins
        mie = 32'h888; mip = 32'h888;
        cq.push_back('{is_mret: 1'b0, cause: 32'h8000_000B, tval: 32'h0, pc: 32'h44});
        rq.push_back(32'h200);
        step();
        mip = 0;
        wait_commit("mei_commit_timeout");
        finish_redirect(0, 32'h200);

        // Exception beats pending interrupts; reserved mtvec mode is direct
        mtvec = 32'h203; mip = 32'h888;
        exc_valid = 1; exc_cause = 32'h5; exc_tval = 32'h77; exc_pc = 32'h120;
        cq.push_back('{is_mret: 1'b0, cause: 32'h5, tval: 32'h77, pc: 32'h120});
        rq.push_back(32'h200);
        step();
        exc_valid = 0; mip = 0;
        wait_commit("exc_prio_commit_timeout");
        chk("exc_prio_cause", trap_cause, 32'h5);
        finish_redirect(0, 32'h200);

        // MRET with redirect back-pressure
        mtvec = 32'h200; mepc = 32'h80; mret = 1;
        cq.push_back('{is_mret: 1'b1, cause: 32'h0, tval: 32'h0, pc: 32'h0});
        rq.push_back(32'h80);
        step();
        mret = 0;
        wait_commit("mret_commit_timeout");
        chk("mret_strobe", 32'(trap_mret), 32'd1);
        chk("mret_no_req", 32'(trap_req), 32'd0);
        finish_redirect(4, 32'h80);

        // mtvec sampled at COMMIT, not at latch
        pipe_drained = 0;
        exc_valid = 1; exc_cause = 32'h1; exc_tval = 0; exc_pc = 32'h10;
        cq.push_back('{is_mret: 1'b0, cause: 32'h1, tval: 32'h0, pc: 32'h10});
        rq.push_back(32'h400);
        step();
        exc_valid = 0; mtvec = 32'h400;
        step();
        pipe_drained = 1;
        wait_commit("late_mtvec_commit_timeout");
        finish_redirect(0, 32'h400);
        chk("no_timeout_yet", 32'(drain_timeout), 32'd0);

        // Drain timeout
        pipe_drained = 0;
        exc_valid = 1; exc_cause = 32'h4; exc_tval = 32'h9; exc_pc = 32'h140;
        cq.push_back('{is_mret: 1'b0, cause: 32'h4, tval: 32'h9, pc: 32'h140});
        rq.push_back(32'h400);
        step();
        exc_valid = 0;
        n = 0;
        while (stall && !trap_req && n < 40) begin
            n++;
            step();
        end
        chk("drain_cycles", 32'(n), 32'(DRAIN_MAX));
        chk("timeout_at_commit", 32'(drain_timeout), 32'd1);
        pipe_drained = 1;
        finish_redirect(0, 32'h400);
        chk("timeout_sticky", 32'(drain_timeout), 32'd1);

        // Interrupts masked in M-mode with mstatus.MIE=0
        mstatus = 0; mie = 32'h888; mip = 32'h008; mtvec = 32'h301;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("masked_irq_idle", 32'(stall), 32'd0);
        end

        // Same interrupt from U-mode is taken; vectored when enabled
        priv = PRIV_U;
        cq.push_back('{is_mret: 1'b0, cause: 32'h8000_0003, tval: 32'h0, pc: 32'h44});
`ifdef TRAP_CTRL_VECTORED_EN
        rq.push_back(32'h30C);
`else
        rq.push_back(32'h300);
`endif
        step();
        mip = 0; priv = PRIV_M;
        wait_commit("msi_commit_timeout");
`ifdef TRAP_CTRL_VECTORED_EN
        finish_redirect(0, 32'h30C);
`else
        finish_redirect(0, 32'h300);
`endif

        // Exceptions always go to base
        exc_valid = 1; exc_cause = 32'h2; exc_tval = 0; exc_pc = 32'h100;
        cq.push_back('{is_mret: 1'b0, cause: 32'h2, tval: 32'h0, pc: 32'h100});
        rq.push_back(32'h300);
        step();
        exc_valid = 0;
        wait_commit("vec_exc_commit_timeout");
        finish_redirect(0, 32'h300);

        // Async reset while redirecting
        exc_valid = 1; exc_cause = 32'h3; exc_tval = 0; exc_pc = 32'h180;
        cq.push_back('{is_mret: 1'b0, cause: 32'h3, tval: 32'h0, pc: 32'h180});
        step();
        exc_valid = 0;
        wait_commit("abort_commit_timeout");
        step();
        chk("abort_in_redirect", 32'(redirect_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl_zero", {flush, stall, trap_req, trap_mret, redirect_valid, drain_timeout}, 32'd0);
        chk("abort_data_zero", trap_cause | trap_tval | trap_pc | redirect_pc, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("cq_empty", 32'(cq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
